prco_lmem_dp: RTL and testbench

//  Parametrised dual-port on-chip local memory: next generation of the core's single-port lmem.

---
 rtl/prco_lmem_dp.sv | 141 ++++++++++++++
 tb/tb_prco_lmem_dp.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/prco_lmem_dp.sv
// Dual-port local memory: port A read-only fetch, port B byte-enabled
// read/write. Both ports respond one cycle after accept; built-in zero-fill.
module prco_lmem_dp #(
  parameter int P_DATA_WIDTH = 16,
  parameter int P_ADDR_WIDTH = 16,
  parameter int P_DEPTH      = 256,
  parameter bit P_INIT_CLEAR = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_clr,
  output logic                      q_ready,
  output logic                      q_busy,
  input  logic                      i_a_req,
  input  logic [P_ADDR_WIDTH-1:0]   i_a_addr,
  output logic                      q_a_ack,
  output logic [P_DATA_WIDTH-1:0]   q_a_dout,
  output logic                      q_a_err,
  input  logic                      i_b_req,
  input  logic                      i_b_we,
  input  logic [P_DATA_WIDTH/8-1:0] i_b_be,
  input  logic [P_ADDR_WIDTH-1:0]   i_b_addr,
  input  logic [P_DATA_WIDTH-1:0]   i_b_din,
  output logic                      q_b_ack,
  output logic [P_DATA_WIDTH-1:0]   q_b_dout,
  output logic                      q_b_err
);

  localparam int LP_NB = P_DATA_WIDTH / 8;
  localparam int LP_CW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam logic [P_ADDR_WIDTH:0] LP_DEPTH =
    (P_ADDR_WIDTH+1)'(P_DEPTH);
  localparam logic [LP_CW-1:0] LP_LAST = LP_CW'(P_DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t                  r_state;
  logic [LP_CW-1:0]        r_cnt;
  logic [P_DATA_WIDTH-1:0] r_mem [P_DEPTH];

  logic                    r_a_ack;
  logic                    r_a_err;
  logic [P_DATA_WIDTH-1:0] r_a_dout;
  logic                    r_b_ack;
  logic                    r_b_err;
  logic [P_DATA_WIDTH-1:0] r_b_dout;

  logic             w_ready;
  logic             w_a_acc;
  logic             w_b_acc;
  logic             w_a_inr;
  logic             w_b_inr;
  logic             w_b_wr;
  logic             w_clr_wr;
  logic [LP_CW-1:0] w_a_idx;
  logic [LP_CW-1:0] w_b_idx;

  assign w_ready  = (r_state == ST_READY);
  assign w_a_acc  = i_a_req && w_ready;
  assign w_b_acc  = i_b_req && w_ready;
  // Range check on the full address so high bits never alias.
  assign w_a_inr  = ({1'b0, i_a_addr} < LP_DEPTH);
  assign w_b_inr  = ({1'b0, i_b_addr} < LP_DEPTH);
  assign w_a_idx  = i_a_addr[LP_CW-1:0];
  assign w_b_idx  = i_b_addr[LP_CW-1:0];
  assign w_b_wr   = w_b_acc && i_b_we && w_b_inr;
  assign w_clr_wr = (r_state == ST_CLEAR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= P_INIT_CLEAR ? ST_CLEAR : ST_READY;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_CLEAR: begin
          if (r_cnt == LP_LAST) begin
            r_state <= ST_READY;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (i_clr) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
        default: r_state <= ST_READY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_ack  <= 1'b0;
      r_a_err  <= 1'b0;
      r_a_dout <= '0;
      r_b_ack  <= 1'b0;
      r_b_err  <= 1'b0;
      r_b_dout <= '0;
    end else begin
      r_a_ack <= w_a_acc;
      r_a_err <= w_a_acc && !w_a_inr;
      r_b_ack <= w_b_acc;
      r_b_err <= w_b_acc && !w_b_inr;
      if (w_a_acc) begin
        r_a_dout <= w_a_inr ? r_mem[w_a_idx] : '0;
      end
      if (w_b_acc) begin
        r_b_dout <= w_b_inr ? r_mem[w_b_idx] : '0;
      end
    end
  end

  // Array write port; reads above see the pre-write word.
  always_ff @(posedge i_clk) begin
    if (w_clr_wr) begin
      r_mem[r_cnt] <= '0;
    end else if (w_b_wr) begin
      for (int n = 0; n < LP_NB; n++) begin
        if (i_b_be[n]) begin
          r_mem[w_b_idx][8*n +: 8] <= i_b_din[8*n +: 8];
        end
      end
    end
  end

  assign q_ready  = w_ready;
  assign q_busy   = !w_ready;
  assign q_a_ack  = r_a_ack;
  assign q_a_err  = r_a_err;
  assign q_a_dout = r_a_dout;
  assign q_b_ack  = r_b_ack;
  assign q_b_err  = r_b_err;
  assign q_b_dout = r_b_dout;

endmodule

// File: tb/tb_prco_lmem_dp.sv
// Bench for prco_lmem_dp: directed cases with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_prco_lmem_dp;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        ready;
  logic        busy;
  logic        a_req;
  logic [15:0] a_addr;
  logic        a_ack;
  logic [15:0] a_dout;
  logic        a_err;
  logic        b_req;
  logic        b_we;
  logic [1:0]  b_be;
  logic [15:0] b_addr;
  logic [15:0] b_din;
  logic        b_ack;
  logic [15:0] b_dout;
  logic        b_err;

  int total = 0;
  int bad   = 0;

  prco_lmem_dp dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_clr    (clr),
    .q_ready  (ready),
    .q_busy   (busy),
    .i_a_req  (a_req),
    .i_a_addr (a_addr),
    .q_a_ack  (a_ack),
    .q_a_dout (a_dout),
    .q_a_err  (a_err),
    .i_b_req  (b_req),
    .i_b_we   (b_we),
    .i_b_be   (b_be),
    .i_b_addr (b_addr),
    .i_b_din  (b_din),
    .q_b_ack  (b_ack),
    .q_b_dout (b_dout),
    .q_b_err  (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: memory image, remaining clear cycles, expected outs.
  logic [15:0] m_mem [256];
  int          m_left;
  logic        e_a_ack, e_a_err, e_b_ack, e_b_err;
  logic [15:0] e_a_dout, e_b_dout;

  task automatic model_step();
    logic [15:0] old_b;
    if (!rst_n) begin
      m_left = 256;
      e_a_ack = 0; e_a_err = 0; e_a_dout = 0;
      e_b_ack = 0; e_b_err = 0; e_b_dout = 0;
      foreach (m_mem[i]) m_mem[i] = 16'h0;
    end else begin
      e_a_ack = 0; e_a_err = 0;
      e_b_ack = 0; e_b_err = 0;
      if (m_left > 0) begin
        m_left--;
      end else begin
        if (a_req) begin
          e_a_ack = 1;
          e_a_err = (a_addr >= 256);
          e_a_dout = e_a_err ? 16'h0 : m_mem[a_addr[7:0]];
        end
        if (b_req) begin
          e_b_ack = 1;
          e_b_err = (b_addr >= 256);
          old_b = e_b_err ? 16'h0 : m_mem[b_addr[7:0]];
          e_b_dout = old_b;
          if (b_we && !e_b_err) begin
            if (b_be[0]) old_b[7:0]  = b_din[7:0];
            if (b_be[1]) old_b[15:8] = b_din[15:8];
            m_mem[b_addr[7:0]] = old_b;
          end
        end
        if (clr) begin
          foreach (m_mem[i]) m_mem[i] = 16'h0;
          m_left = 256;
        end
      end
    end
  endtask

  initial begin
    model_step();
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("ready", ready, m_left == 0);
      chk("busy", busy, m_left != 0);
      chk("a_ack", a_ack, e_a_ack);
      chk("a_err", a_err, e_a_err);
      chk("a_dout", a_dout, e_a_dout);
      chk("b_ack", b_ack, e_b_ack);
      chk("b_err", b_err, e_b_err);
      chk("b_dout", b_dout, e_b_dout);
    end
  end

  // One request cycle: drive, cross the edge, release. Called at posedge+1.
  task automatic step(input logic ar, input logic [15:0] aa,
                      input logic br, input logic bw,
                      input logic [1:0] be, input logic [15:0] ba,
                      input logic [15:0] bd, input logic c);
    a_req = ar; a_addr = aa;
    b_req = br; b_we = bw; b_be = be; b_addr = ba; b_din = bd;
    clr = c;
    @(posedge clk);
    #1;
    a_req = 0; b_req = 0; b_we = 0; clr = 0;
  endtask

  function automatic logic [15:0] raddr();
    int r;
    r = $urandom % 16;
    if (r == 0) return 16'h0100 + 16'($urandom % 4);
    if (r == 1) return 16'hffff;
    if (r < 5) return 16'($urandom % 256);
    return 16'($urandom % 8);
  endfunction

  initial begin
    int n;
    rst_n = 0; clr = 0;
    a_req = 0; a_addr = 0;
    b_req = 0; b_we = 0; b_be = 0; b_addr = 0; b_din = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ready && n < 1000);
    chk("init_clear_len", n, 256);

    step(1, 16'h0005, 0, 0, 2'b00, 0, 0, 0);
    chk("rd_after_clear", {a_ack, a_err, a_dout}, {2'b10, 16'h0000});
    step(0, 0, 1, 1, 2'b11, 16'h0010, 16'habcd, 0);
    chk("wr_pre", {b_ack, b_dout}, {1'b1, 16'h0000});
    step(1, 16'h0010, 0, 0, 2'b00, 0, 0, 0);
    chk("rd_abcd", {a_ack, a_dout}, {1'b1, 16'habcd});
    step(0, 0, 1, 1, 2'b01, 16'h0010, 16'h12ff, 0);
    chk("be01_pre", b_dout, 16'habcd);
    step(1, 16'h0010, 0, 0, 2'b00, 0, 0, 0);
    chk("be01_rd", a_dout, 16'habff);
    step(0, 0, 1, 1, 2'b11, 16'h0020, 16'h1111, 0);
    step(1, 16'h0020, 1, 1, 2'b11, 16'h0020, 16'h2222, 0);
    chk("coll_a_old", a_dout, 16'h1111);
    chk("coll_b_old", b_dout, 16'h1111);
    step(1, 16'h0020, 0, 0, 2'b00, 0, 0, 0);
    chk("coll_after", a_dout, 16'h2222);
    step(1, 16'h0100, 1, 0, 2'b00, 16'h0100, 0, 0);
    chk("oob_a", {a_ack, a_err, a_dout}, {2'b11, 16'h0000});
    chk("oob_b", {b_ack, b_err, b_dout}, {2'b11, 16'h0000});
    step(0, 0, 1, 1, 2'b11, 16'h0100, 16'hffff, 0);
    step(1, 16'h0000, 0, 0, 2'b00, 0, 0, 0);
    chk("oob_no_alias", a_dout, 16'h0000);
    step(0, 0, 1, 1, 2'b00, 16'h0010, 16'h5a5a, 0);
    chk("be00_ack", {b_ack, b_dout}, {1'b1, 16'habff});
    step(1, 16'h0010, 0, 0, 2'b00, 0, 0, 0);
    chk("be00_noop", a_dout, 16'habff);

    step(0, 0, 1, 1, 2'b11, 16'h0030, 16'h5555, 1);
    chk("clr_req_ack", {b_ack, ready}, 2'b10);
    a_req = 1; a_addr = 16'h0030;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!a_ack && n < 1000);
    a_req = 0;
    chk("held_wait", n, 257);
    chk("held_rd_zero", a_dout, 16'h0000);

    repeat (2000) begin
      a_req = 1'($urandom); a_addr = raddr();
      b_req = 1'($urandom); b_we = 1'($urandom);
      b_be = 2'($urandom); b_addr = raddr();
      b_din = 16'($urandom);
      clr = ($urandom % 300 == 0);
      @(posedge clk);
      #1;
    end
    a_req = 0; b_req = 0; clr = 0;
    n = 0;
    while (!ready && n < 1000) begin @(posedge clk); #1; n++; end

    step(0, 0, 0, 0, 2'b00, 0, 0, 1);
    repeat (50) @(posedge clk);
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ready && n < 1000);
    chk("restart_len", n, 256);

    for (int i = 0; i < 256; i++) begin
      step(1, 16'(i), 0, 0, 2'b00, 0, 0, 0);
      chk("sweep_zero", a_dout, 16'h0000);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
